// File: rtl/obi_data_sram_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obi_data_sram_pkg : shared types and constants for the OBI data SRAM
// Rev 1.0
// ---------------------------------------------------------------------------
package obi_data_sram_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [31:0] DMEM_ERR_RDATA = 32'hDEAD_BEEF;
  localparam logic [7:0]  DMEM_LFSR_SEED = 8'hA5;

  // Fibonacci LFSR, taps 8,6,5,4 (bit 7 is tap 8)
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_data_sram_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obi_data_sram_if : req/gnt/rvalid data port between LSU and data SRAM
// Rev 1.0
// ---------------------------------------------------------------------------
interface obi_data_sram_if;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o
  );
endinterface
`default_nettype wire

// File: rtl/dmem_gnt_stall_lfsr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_gnt_stall_lfsr : pseudo-random grant stall source (DMEM_GNT_STALL_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
`ifdef DMEM_GNT_STALL_EN
module dmem_gnt_stall_lfsr
  import obi_data_sram_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic stall_o
);

  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= DMEM_LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign stall_o = (lfsr[1:0] == 2'b00);

endmodule
`endif
`default_nettype wire

// File: rtl/obi_data_sram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obi_data_sram : single-outstanding OBI data memory with tohost decode.
// Optional DMEM_GNT_STALL_EN injects LFSR-driven grant stalls. Rev 1.0
// ---------------------------------------------------------------------------
module obi_data_sram
  import obi_data_sram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int unsigned RVALID_LATENCY = 1,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0600
) (
  input  logic              clk,
  input  logic              reset,
  obi_data_sram_if.slave    bus,
  output logic              err_o,
  output logic [31:0]       tohost_o,
  output logic              tohost_valid_o
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);
  localparam logic [1:0]  CNT_INIT  = 2'(RVALID_LATENCY - 1);

  state_e      state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        stall_inj;
  logic        accept;
  logic        resp_now;
  logic        in_range;
  logic        is_tohost;
  logic [31:0] offset;
  logic [IDX_W-1:0] widx;
  logic [31:0] mem [DEPTH_WORDS];
  logic        unused_bits;

`ifdef DMEM_GNT_STALL_EN
  dmem_gnt_stall_lfsr u_stall (
    .clk     (clk),
    .reset   (reset),
    .stall_o (stall_inj)
  );
`else
  assign stall_inj = 1'b0;
`endif

  // Unsigned subtraction: addresses below the base wrap to a huge index.
  assign offset      = bus.data_addr_i - ADDR_BASE;
  assign widx        = offset[IDX_W+1:2];
  assign in_range    = (bus.data_addr_i >= ADDR_BASE) && (offset[31:2] < DEPTH_W30);
  assign is_tohost   = (bus.data_addr_i[31:2] == TOHOST_ADDR[31:2]);
  assign unused_bits = ^offset[1:0];

  // The response cycle also accepts, so a new request overlaps the rvalid pulse.
  assign resp_now = (state == S_WAIT) && (cnt == 2'd0);
  assign accept   = bus.data_req_i && !stall_inj && !reset &&
                    ((state == S_IDLE) || resp_now);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next        = state;
    cnt_next          = cnt;
    bus.data_gnt_o    = accept;
    bus.data_rvalid_o = resp_now && !reset;
    bus.data_rdata_o  = 32'h0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt != 2'd0) begin
          cnt_next = cnt - 2'd1;
        end else if (accept) begin
          state_next = S_WAIT;
          cnt_next   = CNT_INIT;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (bus.data_rvalid_o && !we_q) bus.data_rdata_o = rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q           <= 1'b0;
      rdata_q        <= 32'h0;
      err_o          <= 1'b0;
      tohost_o       <= 32'h0;
      tohost_valid_o <= 1'b0;
    end else begin
      tohost_valid_o <= accept && bus.data_we_i && in_range && is_tohost;
      if (accept) begin
        we_q    <= bus.data_we_i;
        rdata_q <= in_range ? mem[widx] : DMEM_ERR_RDATA;
        if (!in_range) err_o <= 1'b1;
        if (bus.data_we_i && in_range && is_tohost) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.data_be_i[b]) tohost_o[8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && bus.data_we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be_i[b]) mem[widx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire
